code_seq: RTL and testbench
===========================

# code_seq

Upstream code sequencer for the 4-bit combinational decoder `comb`. It walks a programmable range of input codes, ascending or descending with modular wrap-around, and presents one code per transfer on a valid/ready handshake. The consumer is `comb`'s `i` input, or a register stage in front of it. The block replaces the testbench-style exhaustive sweep with a synthesizable, restartable, abortable source.

## Interface
- `W`, default 4: code width.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_b`  in  1: asynchronous, active-low reset.
- `start`  in  1: start pulse; honoured only in IDLE.
- `stop`  in  1: abort request; honoured only in RUN.
- `first`  in  W: first code of the range; sampled on the accepted `start`.
- `last`  in  W: final code of the range; sampled on the accepted `start`.
- `dir`  in  1: 0 = ascending, 1 = descending; sampled on the accepted `start`.
- `ready`  in  1: consumer accepts `code` this cycle.
- `code`  out  W: registered output code.
- `valid`  out  1: `code` is meaningful.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle pulse after the final transfer.
- `wrap`  out  1: one-cycle pulse on a transfer that crosses the modulo boundary.

## Operation
- States are IDLE, RUN and DONE. Reset and power-up state is IDLE.
- IDLE
  - Outputs are 0.
  - `start` latches `first`, `last` and `dir`, sets `cnt = first`, and moves to RUN.
  - If `stop` is high in the same cycle, the `start` is ignored.
- RUN
  - `valid = 1` and `code = cnt`.
  - A transfer happens on each edge with `valid && ready`.
  - On a transfer:
    - If `cnt == last_q`, move to DONE.
    - Otherwise `cnt = cnt ± 1 mod 2^W`.
- DONE
  - `valid = 0` and `done = 1` for exactly one cycle.
  - Then move to IDLE. `start` is ignored in DONE.
- `stop` in RUN
  - On the next edge, move to IDLE and drop `valid`.
  - A transfer on that same edge still counts as accepted.
  - `done` is never asserted after an abort.
- Wrap-around
  - Ascending: a transfer with `cnt == 2^W−1` and `cnt != last_q` sets `wrap = 1` in the following cycle, and the next code is 0.
  - Descending: the boundary is `cnt == 0`, and the next code is `2^W−1`.
- Range length is `((last−first) mod 2^W) + 1` transfers ascending, or `((first−last) mod 2^W) + 1` descending.
  - `first == last` gives exactly one transfer.
  - All comparisons are unsigned, W-bit, in the binary domain.
- Handshake rules
  - Once `valid` is high, `code` holds stable until a transfer, an abort or reset.
  - `valid` never drops without a transfer, except on `stop` or reset.
- Reset mid-operation: all state and outputs return to IDLE/0 immediately, with no `done` pulse.

## Timing
- Accepted `start` on edge n: `valid = 1` and `code = first` from edge n+1.
- Throughput is one code per cycle with `ready` held high, with no bubbles.
- Final transfer on edge k:
  - `done = 1` and `valid = 0` during cycle k+1.
  - IDLE from edge k+2.
  - The earliest new `start` is sampled on edge k+2.
- `wrap` is asserted in the cycle after the crossing transfer, aligned with the first post-wrap code.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `CODE_SEQ_GRAY_EN`
  - Defined: `code` carries the Gray encoding of `cnt` (`cnt ^ (cnt >> 1)`). `first`, `last`, wrap detection and range length stay in the binary domain.
  - Undefined: `code = cnt` in binary. The Gray encoder is not elaborated.

## Structure
- Shared package `code_seq_pkg` contains:
  - `state_t` enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Constant `CODE_W = 4`.
- Sub-module `bin2gray` (parameter W, purely combinational) is instantiated only under `CODE_SEQ_GRAY_EN`.

## Test plan
- Full sweep: `first=0`, `last=15`, `dir=0`, `ready` held 1 → 16 transfers 0..15 on consecutive cycles, `wrap` never asserted, `done` 1 cycle after code 15.
- Descending wrap: `first=3`, `last=14`, `dir=1` → codes 3,2,1,0,15,14, `wrap=1` in the cycle `code=15`, 6 transfers then `done`.
- Backpressure: `first=5`, `last=7`, `ready` low for 3 cycles at code 6 → `code=6` and `valid=1` stable throughout, sequence 5,6,7 unchanged.
- Abort and restart: `stop` during `code=9` of range 8..12 → `valid` falls next cycle, no `done`, and a `start` with `first=2`, `last=2` then gives a single transfer of code 2 plus `done`.
- Async reset: `rst_b` low mid-RUN, between clock edges → `valid`, `busy`, `done`, `wrap` and `code` are 0 immediately. With `start` and `stop` both high in IDLE, the block stays in IDLE.
- Gray build (`CODE_SEQ_GRAY_EN`): range 0..15 ascending → `code` sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8.

Source files
------------

// File: rtl/code_seq_pkg.sv
// Shared types and constants for the code_seq range sequencer.
package code_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CODE_W = 4;

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray encoder.
module bin2gray #(
    parameter int W = 4
) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/code_seq.sv
// Range code sequencer with valid/ready output and modular wrap-around.
// CODE_SEQ_GRAY_EN: present the count Gray-encoded on code.
module code_seq
    import code_seq_pkg::*;
#(
    parameter int W = CODE_W
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] first,
    input  logic [W-1:0] last,
    input  logic         dir,
    input  logic         ready,
    output logic [W-1:0] code,
    output logic         valid,
    output logic         busy,
    output logic         done,
    output logic         wrap
);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] MAX = '1;

    state_t       state, state_n;
    logic [W-1:0] cnt, cnt_n;
    logic [W-1:0] last_q, last_n;
    logic         dir_q, dir_n;
    logic         wrap_q, wrap_n;
    logic         at_edge;
    logic [W-1:0] enc;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= IDLE;
            cnt    <= '0;
            last_q <= '0;
            dir_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            last_q <= last_n;
            dir_q  <= dir_n;
            wrap_q <= wrap_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last_q;
        dir_n   = dir_q;
        wrap_n  = 1'b0;
        at_edge = dir_q ? (cnt == '0) : (cnt == MAX);
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_n = RUN;
                    cnt_n   = first;
                    last_n  = last;
                    dir_n   = dir;
                end
            end
            RUN: begin
                // abort wins; a same-edge transfer needs no extra action
                if (stop) begin
                    state_n = IDLE;
                end else if (ready) begin
                    if (cnt == last_q) begin
                        state_n = DONE;
                    end else begin
                        cnt_n  = dir_q ? cnt - ONE : cnt + ONE;
                        wrap_n = at_edge;
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

`ifdef CODE_SEQ_GRAY_EN
    bin2gray #(.W(W)) u_gray (
        .bin  (cnt),
        .gray (enc)
    );
`else
    assign enc = cnt;
`endif

    assign valid = (state == RUN);
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign wrap  = wrap_q;
    assign code  = valid ? enc : '0;

endmodule

// File: tb/tb_code_seq.sv
// Self-checking bench for code_seq: directed plan steps plus random traffic
// checked against a sequence-list reference model.
module tb_code_seq;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] first = '0;
    logic [3:0] last = '0;
    logic       dir = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] code;
    logic       valid;
    logic       busy;
    logic       done;
    logic       wrap;

    int n_cmp = 0;
    int n_bad = 0;

    // model: 0 idle, 1 streaming, 2 done pulse
    int         m = 0;
    logic [3:0] seq[$];
    int         idx = 0;
    bit         pw = 1'b0;
    bit         md = 1'b0;

    code_seq #(.W(4)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .start (start),
        .stop  (stop),
        .first (first),
        .last  (last),
        .dir   (dir),
        .ready (ready),
        .code  (code),
        .valid (valid),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] enc(logic [3:0] v);
`ifdef CODE_SEQ_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        logic [3:0] ec;
        ec = (m == 1) ? enc(seq[idx]) : 4'h0;
        chk("valid", {3'b0, valid}, {3'b0, m == 1});
        chk("code", code, ec);
        chk("busy", {3'b0, busy}, {3'b0, m != 0});
        chk("done", {3'b0, done}, {3'b0, m == 2});
        chk("wrap", {3'b0, wrap}, {3'b0, (m == 1) && pw});
    endtask

    task automatic model_edge(bit s, bit p, bit r,
                              logic [3:0] f, logic [3:0] l, bit d);
        logic [3:0] span;
        logic [3:0] v;
        int n;
        case (m)
            0: if (s && !p) begin
                span = d ? f - l : l - f;
                n = int'(span) + 1;
                seq.delete();
                for (int i = 0; i < n; i++) begin
                    v = d ? f - 4'(i) : f + 4'(i);
                    seq.push_back(v);
                end
                m = 1;
                idx = 0;
                pw = 1'b0;
                md = d;
            end
            1: begin
                pw = 1'b0;
                if (p) begin
                    m = 0;
                end else if (r) begin
                    if (idx == seq.size() - 1) begin
                        m = 2;
                    end else begin
                        pw = (seq[idx] == (md ? 4'h0 : 4'hf));
                        idx++;
                    end
                end
            end
            default: m = 0;
        endcase
    endtask

    task automatic step(bit s, bit p, bit r,
                        logic [3:0] f, logic [3:0] l, bit d);
        start = s;
        stop = p;
        ready = r;
        first = f;
        last = l;
        dir = d;
        @(posedge clk);
        model_edge(s, p, r, f, l, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic go(logic [3:0] f, logic [3:0] l, bit d);
        step(1'b1, 1'b0, 1'b1, f, l, d);
    endtask

    task automatic run(int n, bit r);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, r, 4'h0, 4'h0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all();
        rst_b = 1'b1;

        // full ascending sweep
        go(4'h0, 4'hf, 1'b0);
        run(18, 1'b1);

        // descending across the zero boundary
        go(4'h3, 4'he, 1'b1);
        run(8, 1'b1);

        // backpressure on code 6
        go(4'h5, 4'h7, 1'b0);
        run(1, 1'b1);
        run(3, 1'b0);
        run(4, 1'b1);

        // abort during code 9, then single-code range
        go(4'h8, 4'hc, 1'b0);
        run(1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
        run(2, 1'b1);
        go(4'h2, 4'h2, 1'b0);
        run(3, 1'b1);

        // start together with stop stays idle
        step(1'b1, 1'b1, 1'b1, 4'h4, 4'h6, 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'h4, 4'h6, 1'b0);

        // asynchronous reset between edges
        go(4'h1, 4'ha, 1'b0);
        run(3, 1'b1);
        #2 rst_b = 1'b0;
        #1;
        chk("rst_valid", {3'b0, valid}, 4'h0);
        chk("rst_busy", {3'b0, busy}, 4'h0);
        chk("rst_done", {3'b0, done}, 4'h0);
        chk("rst_wrap", {3'b0, wrap}, 4'h0);
        chk("rst_code", code, 4'h0);
        m = 0;
        pw = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        run(2, 1'b1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) == 0, ($urandom % 16) == 0,
                 ($urandom % 4) != 0, 4'($urandom), 4'($urandom),
                 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
